// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 800x600 VGA timing constants and bounding-box types
package vga_pkg;

    localparam int VGA_H_TOTAL     = 1056;
    localparam int VGA_H_ACT_START = 216;
    localparam int VGA_H_ACT       = 800;
    localparam int VGA_V_TOTAL     = 628;
    localparam int VGA_V_ACT_START = 27;
    localparam int VGA_V_ACT       = 600;

    localparam int HCNT_W = 11;
    localparam logic [HCNT_W-1:0] HCNT_SAT = '1;

    // Packed {hi, lo} form handed back to the drawer when nothing was seen.
    localparam logic [31:0] BOX_EMPTY = {16'h0000, 16'hFFFF};

    typedef struct packed {
        logic [15:0] max_x;
        logic [15:0] min_x;
        logic [15:0] max_y;
        logic [15:0] min_y;
    } bbox_t;

    localparam bbox_t BBOX_CLEAR = {BOX_EMPTY, BOX_EMPTY};

endpackage

// File: rtl/vga_bbox_acc.sv
// rtl/vga_bbox_acc.sv - per-colour bounding box accumulator with frame commit
module vga_bbox_acc
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pix,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        clr,
    input  logic        commit,
    output bbox_t       box,
    output logic        hit
);

    bbox_t acc;
    logic  acc_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= BBOX_CLEAR;
            acc_hit <= 1'b0;
            box     <= '0;
            hit     <= 1'b0;
        end else if (en) begin
            if (commit) begin
                box <= acc;
                hit <= acc_hit;
            end
            // Clear wins: the frame-end strobe always falls in blanking.
            if (clr) begin
                acc     <= BBOX_CLEAR;
                acc_hit <= 1'b0;
            end else if (pix) begin
                if (x < acc.min_x) acc.min_x <= x;
                if (x > acc.max_x) acc.max_x <= x;
                if (y < acc.min_y) acc.min_y <= y;
                if (y > acc.max_y) acc.max_y <= y;
                acc_hit <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_rect_capture.sv
// rtl/vga_rect_capture.sv - VGA receive-side sync recovery and per-frame red/green box capture
module vga_rect_capture
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_ACT_START = VGA_H_ACT_START,
    parameter int H_ACT       = VGA_H_ACT,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_ACT_START = VGA_V_ACT_START,
    parameter int V_ACT       = VGA_V_ACT
) (
    input  logic        CLK,
    input  logic        RST_BTN,
    input  logic        pix_stb,
    input  logic        VGA_HS_I,
    input  logic        VGA_VS_I,
    input  logic [3:0]  VGA_R_I,
    input  logic [3:0]  VGA_G_I,
    output logic [31:0] rect_a_x,
    output logic [31:0] rect_a_y,
    output logic [31:0] rect_b_x,
    output logic [31:0] rect_b_y,
    output logic        rect_a_hit,
    output logic        rect_b_hit,
    output logic        frame_stb,
    output logic        locked
);

    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_A0   = HCNT_W'(H_ACT_START);
    localparam logic [HCNT_W-1:0] H_A1   = HCNT_W'(H_ACT_START + H_ACT);
    localparam logic [15:0]       V_LAST = 16'(V_TOTAL - 1);
    localparam logic [15:0]       V_A0   = 16'(V_ACT_START);
    localparam logic [15:0]       V_A1   = 16'(V_ACT_START + V_ACT);

    logic              hs_q, vs_q, r_q, g_q, hs_p, vs_p;
    logic              hs_rise, vs_rise;
    logic [HCNT_W-1:0] hcnt, hcnt_nxt;
    logic [15:0]       vcnt, vcnt_nxt;
    logic              frame_good, line_bad, good_frame, active;
    logic [15:0]       x, y;
    bbox_t             box_a, box_b;
    logic              unused_bits;

    assign unused_bits = ^{VGA_R_I[2:0], VGA_G_I[2:0]};

    assign hs_rise = hs_q & ~hs_p;
    assign vs_rise = vs_q & ~vs_p;

    // Next-state counters line up with the pixel currently held in r_q/g_q.
    always_comb begin
        hcnt_nxt = hcnt;
        if (hs_rise)
            hcnt_nxt = '0;
        else if (hcnt != HCNT_SAT)
            hcnt_nxt = hcnt + 1'b1;
        vcnt_nxt = vcnt;
        if (vs_rise)
            vcnt_nxt = '0;
        else if (hs_rise)
            vcnt_nxt = vcnt + 1'b1;
    end

    assign active = (hcnt_nxt >= H_A0) && (hcnt_nxt < H_A1) &&
                    (vcnt_nxt >= V_A0) && (vcnt_nxt < V_A1);
    assign x = 16'(hcnt_nxt - H_A0);
    assign y = vcnt_nxt - V_A0;

    assign line_bad   = hs_rise && (hcnt != H_LAST);
    assign good_frame = frame_good && !line_bad && (vcnt == V_LAST);

    always_ff @(posedge CLK or posedge RST_BTN) begin
        if (RST_BTN) begin
            {hs_q, vs_q, r_q, g_q, hs_p, vs_p} <= '0;
            hcnt       <= HCNT_SAT;
            vcnt       <= '0;
            frame_good <= 1'b0;
            locked     <= 1'b0;
            frame_stb  <= 1'b0;
        end else begin
            frame_stb <= 1'b0;
            if (pix_stb) begin
                hs_q <= VGA_HS_I;
                vs_q <= VGA_VS_I;
                r_q  <= VGA_R_I[3];
                g_q  <= VGA_G_I[3];
                hs_p <= hs_q;
                vs_p <= vs_q;
                hcnt <= hcnt_nxt;
                vcnt <= vcnt_nxt;
                if (hcnt_nxt == HCNT_SAT)
                    locked <= 1'b0;
                if (line_bad) begin
                    frame_good <= 1'b0;
                    locked     <= 1'b0;
                end
                if (vs_rise) begin
                    frame_good <= 1'b1;
                    locked     <= good_frame;
                    frame_stb  <= good_frame;
                end
            end
        end
    end

    vga_bbox_acc u_acc_a (
        .clk    (CLK),
        .rst    (RST_BTN),
        .en     (pix_stb),
        .pix    (active & r_q),
        .x      (x),
        .y      (y),
        .clr    (vs_rise),
        .commit (vs_rise & good_frame),
        .box    (box_a),
        .hit    (rect_a_hit)
    );

    vga_bbox_acc u_acc_b (
        .clk    (CLK),
        .rst    (RST_BTN),
        .en     (pix_stb),
        .pix    (active & g_q),
        .x      (x),
        .y      (y),
        .clr    (vs_rise),
        .commit (vs_rise & good_frame),
        .box    (box_b),
        .hit    (rect_b_hit)
    );

    assign rect_a_x = {box_a.max_x, box_a.min_x};
    assign rect_a_y = {box_a.max_y, box_a.min_y};
    assign rect_b_x = {box_b.max_x, box_b.min_x};
    assign rect_b_y = {box_b.max_y, box_b.min_y};

endmodule

// File: tb/tb_vga_rect_capture.sv
// tb/tb_vga_rect_capture.sv - directed bench for vga_rect_capture on a scaled-down raster
module tb_vga_rect_capture;
    import vga_pkg::*;

    localparam int HT = 48, HAS = 10, HA = 32, HSW = 6;
    localparam int VT = 20, VAS = 3, VA = 16, VSW = 2;

    logic        CLK = 1'b0;
    logic        RST_BTN, pix_stb, hs, vs;
    logic [3:0]  r, g;
    logic [31:0] a_x, a_y, b_x, b_y;
    logic        a_hit, b_hit, frame_stb, locked;
    int          n_vec = 0, n_bad = 0, stb_cnt = 0, stb_mark;

    vga_rect_capture #(
        .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACT(HA),
        .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACT(VA)
    ) dut (
        .CLK        (CLK),
        .RST_BTN    (RST_BTN),
        .pix_stb    (pix_stb),
        .VGA_HS_I   (hs),
        .VGA_VS_I   (vs),
        .VGA_R_I    (r),
        .VGA_G_I    (g),
        .rect_a_x   (a_x),
        .rect_a_y   (a_y),
        .rect_b_x   (b_x),
        .rect_b_y   (b_y),
        .rect_a_hit (a_hit),
        .rect_b_hit (b_hit),
        .frame_stb  (frame_stb),
        .locked     (locked)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (frame_stb) stb_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put(input logic h, input logic v, input logic [3:0] rr, input logic [3:0] gg);
        @(negedge CLK);
        hs = h; vs = v; r = rr; g = gg; pix_stb = 1'b1;
        @(negedge CLK);
        pix_stb = 1'b0;
    endtask

    // Drawer model: colour drawn where lo < x < hi and lo < y < hi (strict).
    task automatic draw(input int l0, input int l1, input int bad_line,
                        input int rx0, input int rx1, input int ry0, input int ry1,
                        input int gx0, input int gx1, input int gy0, input int gy1);
        int  len, x, y;
        bit  act, rd, gr;
        for (int l = l0; l <= l1; l++) begin
            len = (l == bad_line) ? HT - 1 : HT;
            for (int p = 0; p < len; p++) begin
                x   = p - HAS;
                y   = l - VAS;
                act = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
                rd  = act && (x > rx0) && (x < rx1) && (y > ry0) && (y < ry1);
                gr  = act && (x > gx0) && (x < gx1) && (y > gy0) && (y < gy1);
                put(p < HSW, l < VSW,
                    rd ? 4'b1000 : (act ? 4'b0111 : 4'b0000),
                    gr ? 4'b1000 : (act ? 4'b0111 : 4'b0000));
            end
        end
    endtask

    task automatic frame(input int bad_line,
                         input int rx0, input int rx1, input int ry0, input int ry1,
                         input int gx0, input int gx1, input int gy0, input int gy1);
        draw(0, VT - 1, bad_line, rx0, rx1, ry0, ry1, gx0, gx1, gy0, gy1);
    endtask

    initial begin
        RST_BTN = 1'b1; pix_stb = 1'b0; hs = 1'b0; vs = 1'b0; r = '0; g = '0;
        repeat (3) @(negedge CLK);
        check("rst_a_x", a_x, 32'h0);
        check("rst_b_y", b_y, 32'h0);
        check("rst_hits", {30'h0, a_hit, b_hit}, 32'h0);
        check("rst_lock_stb", {30'h0, locked, frame_stb}, 32'h0);
        RST_BTN = 1'b0;

        frame(-1, 4, 20, 2, 10, 0, 0, 0, 0);
        check("f0_no_stb", stb_cnt, 0);
        check("f0_unlocked", {31'h0, locked}, 32'h0);

        frame(-1, -1, 1, -1, 1, 0, 0, 0, 0);
        check("box_stb", stb_cnt, 1);
        check("box_a_x", a_x, {16'd19, 16'd5});
        check("box_a_y", a_y, {16'd9, 16'd3});
        check("box_a_hit", {31'h0, a_hit}, 32'h1);
        check("nogreen_hit", {31'h0, b_hit}, 32'h0);
        check("nogreen_x", b_x, BOX_EMPTY);
        check("nogreen_y", b_y, BOX_EMPTY);
        check("nogreen_lock", {31'h0, locked}, 32'h1);

        frame(-1, 30, 32, 14, 16, 0, 0, 0, 0);
        check("org_stb", stb_cnt, 2);
        check("org_a_x", a_x, 32'h0);
        check("org_a_y", a_y, 32'h0);

        frame(-1, 0, 0, 0, 0, 10, 13, -1, 16);
        check("end_stb", stb_cnt, 3);
        check("end_a_x", a_x, {16'd31, 16'd31});
        check("end_a_y", a_y, {16'd15, 16'd15});

        frame(8, 0, 0, 0, 0, 0, 0, 0, 0);
        check("grn_stb", stb_cnt, 4);
        check("grn_a_x", a_x, BOX_EMPTY);
        check("grn_a_hit", {31'h0, a_hit}, 32'h0);
        check("grn_b_x", b_x, {16'd12, 16'd11});
        check("grn_b_y", b_y, {16'd15, 16'd0});
        check("grn_b_hit", {31'h0, b_hit}, 32'h1);
        check("badline_unlock", {31'h0, locked}, 32'h0);

        frame(-1, 0, 3, 5, 7, 0, 0, 0, 0);
        check("badframe_no_stb", stb_cnt, 4);
        check("badframe_lock", {31'h0, locked}, 32'h0);
        check("badframe_hold", b_x, {16'd12, 16'd11});

        frame(-1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("relock_stb", stb_cnt, 5);
        check("relock_a_x", a_x, {16'd2, 16'd1});
        check("relock_a_y", a_y, {16'd6, 16'd6});
        check("relock_b_hit", {31'h0, b_hit}, 32'h0);
        check("relock_lock", {31'h0, locked}, 32'h1);

        repeat (2100) put(1'b0, 1'b0, 4'h0, 4'h0);
        check("sat_unlock", {31'h0, locked}, 32'h0);
        check("sat_hold", a_x, {16'd2, 16'd1});
        check("sat_no_stb", stb_cnt, 5);

        frame(-1, 4, 20, 2, 10, 0, 0, 0, 0);
        check("postsat_no_stb", stb_cnt, 5);
        frame(-1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("postsat_stb", stb_cnt, 6);
        check("postsat_a_x", a_x, {16'd19, 16'd5});
        check("postsat_lock", {31'h0, locked}, 32'h1);

        draw(0, 9, -1, 4, 20, 2, 10, 0, 0, 0, 0);
        @(negedge CLK);
        RST_BTN = 1'b1;
        #1;
        check("midrst_a_x", a_x, 32'h0);
        check("midrst_b_y", b_y, 32'h0);
        check("midrst_flags", {28'h0, a_hit, b_hit, locked, frame_stb}, 32'h0);
        @(negedge CLK);
        RST_BTN = 1'b0;
        stb_mark = stb_cnt;
        draw(10, VT - 1, -1, 4, 20, 2, 10, 0, 0, 0, 0);
        frame(-1, 20, 25, 11, 15, 0, 0, 0, 0);
        check("rst_vs1_no_stb", stb_cnt - stb_mark, 0);
        frame(-1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_vs2_stb", stb_cnt - stb_mark, 1);
        check("rst_vs2_a_x", a_x, {16'd24, 16'd21});
        check("rst_vs2_a_y", a_y, {16'd14, 16'd12});
        check("rst_vs2_lock", {31'h0, locked}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
